instr_encoder: RTL
==================

# instr_encoder

Program loader front end for the single-cycle core. It accepts symbolic instructions (op enum plus register, immediate and target fields) over a valid/ready handshake and packs them into 32-bit words in the format the control decoder consumes. Packed words are written sequentially into instruction memory through a back-pressured write port, starting at a programmable base address. It is used by the bench and by boot logic to fill imem before the core is released from reset.

## Interface
**Parameters**
- ADDR_W, default 10: imem word-address width.

**Ports**
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: pulse that begins a load; honoured only in IDLE.
- base_addr, input, ADDR_W: first write address, sampled on start.
- in_valid, input, 1: instruction fields are valid.
- in_ready, output, 1: encoder accepts this cycle.
- in_op, input, 4: op enum (isa_pkg::op_e).
- in_rs, in_rt, in_rd, input, 5 each: register fields.
- in_imm, input, 16: immediate.
- in_target, input, 26: jump target.
- in_last, input, 1: final instruction of the load.
- wr_en, output, 1: write request to imem.
- wr_ready, input, 1: imem accepts the write.
- wr_addr, output, ADDR_W: word address.
- wr_data, output, 32: encoded instruction.
- busy, output, 1: state is not IDLE.
- done, output, 1: one-cycle pulse at end of load.
- count, output, ADDR_W+1: words written in the current load.
- err_illegal, output, 1: sticky; an op enum of 11..15 was seen.
- err_overflow, output, 1: sticky; write address wrapped.

## Operation
- Opcode is bits [31:26]; rs is [25:21], rt is [20:16], rd is [15:11]; bits [10:0] are zero for R-type.
- I-type: imm in [15:0]. J-type: target in [25:0].
- Op enum to opcode and format:
  - AND=0: 100000, R.
  - LW=1: 100011, I.
  - SW=2: 101011, I.
  - JR=3: 001000, R with rt=rd=0.
  - JAL=4: 000011, J.
  - NOR=5: 100110, R.
  - NORI=6: 001110, I.
  - NOT=7: 000100, R with rt forced to 0.
  - BLEU=8: 010000, I; imm is the branch offset.
  - ROLV=9: 000000, R.
  - RORV=10: 000010, R.
- Fields that an op does not use are forced to zero regardless of input.
- FSM states:
  - IDLE: start moves to LOAD; wr_addr loads base_addr; count and both errors clear.
  - LOAD: accepts instructions. It moves to DRAIN after accepting in_last, or after the write at address 2^ADDR_W-1 completes. The latter sets err_overflow, and any further input is refused.
  - DRAIN: waits until the output register is empty, then moves to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
- Illegal op (11..15): the beat is consumed and no write is issued. err_illegal sets, and address and count are unchanged. in_last on an illegal beat still ends the load.
- Address and count: on each wr_en & wr_ready, wr_addr increments by 1 (modulo 2^ADDR_W) and count increments by 1.
- start outside IDLE is ignored.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, count=0, err_illegal=0, err_overflow=0; state=IDLE.
- in_ready = (state==LOAD) & (!wr_en | wr_ready). This gives a single output register with pass-through ready, so full throughput is one word per cycle.
- Latency: a beat accepted at edge N produces wr_en, wr_addr and wr_data valid in the cycle after edge N.
- While wr_en=1 & wr_ready=0: wr_addr and wr_data hold stable and in_ready=0.
- Simultaneous accept and write completion: the output register reloads in the same edge, with no bubble.
- done fires 1 cycle after the last write completes (DRAIN→DONE). busy deasserts the cycle after done.
- Reset mid-load aborts immediately. No partial write is replayed, and imem contents are not the encoder's concern.

## Structure
- isa_pkg holds:
  - op_e enum;
  - 6-bit opcode localparams (OPC_AND … OPC_RORV);
  - format enum fmt_e {R, I, J};
  - state enum.
- The control decoder imports the same opcode constants, so encoder and decoder cannot drift.
- Sub-module instr_pack: purely combinational op_e plus fields to {word, illegal}. The top level holds the FSM, output register, address counter and error flags.

## Test plan
- AND rs=1 rt=2 rd=3, base 0x010, in_last=1 → one write, addr 0x010, data 0x80221800; done pulses; count=1.
- LW rs=4 rt=5 imm=0x0010 followed by JAL target=0x40, wr_ready held 1 → back-to-back writes 0x8C850010 @base and 0x0C000040 @base+1, with no idle cycle.
- NOT rs=6 rt=7 rd=8 → data 0x10C04000, confirming rt was forced to 0.
- Stream of 3 words with wr_ready low for 4 cycles on the second → in_ready=0 during the stall; wr_data and wr_addr stable; final count=3.
- Op 12 mid-stream between two ANDs → err_illegal=1; only 2 writes occur, at consecutive addresses.
- ADDR_W=4, base 0xE, 5 beats → writes at 0xE and 0xF, then err_overflow=1 and done pulses; remaining beats are refused. A reset asserted during a later load returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions: op enum, 6-bit opcodes, instruction formats and
// loader FSM states. The control decoder imports the same opcode constants.
package isa_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_LW   = 4'd1,
    OP_SW   = 4'd2,
    OP_JR   = 4'd3,
    OP_JAL  = 4'd4,
    OP_NOR  = 4'd5,
    OP_NORI = 4'd6,
    OP_NOT  = 4'd7,
    OP_BLEU = 4'd8,
    OP_ROLV = 4'd9,
    OP_RORV = 4'd10
  } op_e;

  localparam logic [5:0] OPC_AND  = 6'b100000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_JR   = 6'b001000;
  localparam logic [5:0] OPC_JAL  = 6'b000011;
  localparam logic [5:0] OPC_NOR  = 6'b100110;
  localparam logic [5:0] OPC_NORI = 6'b001110;
  localparam logic [5:0] OPC_NOT  = 6'b000100;
  localparam logic [5:0] OPC_BLEU = 6'b010000;
  localparam logic [5:0] OPC_ROLV = 6'b000000;
  localparam logic [5:0] OPC_RORV = 6'b000010;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: op enum plus fields to a 32-bit instruction word.
// Ports: op_i (op enum), rs_i/rt_i/rd_i, imm_i, target_i in;
//        word_o (packed word, zero when illegal), illegal_o (op 11..15) out.
module instr_pack
  import isa_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [5:0] opc;
  fmt_e       fmt;
  logic       zero_rt;
  logic       zero_rd;
  logic [4:0] rt_eff;
  logic [4:0] rd_eff;

  // Opcode, format and per-op field suppression
  always_comb begin
    opc       = 6'b000000;
    fmt       = FMT_R;
    zero_rt   = 1'b0;
    zero_rd   = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_AND:  opc = OPC_AND;
      OP_LW:   begin opc = OPC_LW;   fmt = FMT_I; end
      OP_SW:   begin opc = OPC_SW;   fmt = FMT_I; end
      OP_JR:   begin opc = OPC_JR;   zero_rt = 1'b1; zero_rd = 1'b1; end
      OP_JAL:  begin opc = OPC_JAL;  fmt = FMT_J; end
      OP_NOR:  opc = OPC_NOR;
      OP_NORI: begin opc = OPC_NORI; fmt = FMT_I; end
      OP_NOT:  begin opc = OPC_NOT;  zero_rt = 1'b1; end
      OP_BLEU: begin opc = OPC_BLEU; fmt = FMT_I; end
      OP_ROLV: opc = OPC_ROLV;
      OP_RORV: opc = OPC_RORV;
      default: illegal_o = 1'b1;
    endcase
  end

  assign rt_eff = zero_rt ? 5'd0 : rt_i;
  assign rd_eff = zero_rd ? 5'd0 : rd_i;

  // Field placement; unused fields of each format never reach the word
  always_comb begin
    word_o = 32'd0;
    case (fmt)
      FMT_R:   word_o = {opc, rs_i, rt_eff, rd_eff, 11'd0};
      FMT_I:   word_o = {opc, rs_i, rt_i, imm_i};
      FMT_J:   word_o = {opc, target_i};
      default: word_o = 32'd0;
    endcase
    if (illegal_o) word_o = 32'd0;
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader front end: accepts symbolic instructions over valid/ready,
// packs them and writes them sequentially into imem from a base address.
// Ports: clk, reset (async, active high); start/base_addr begin a load;
//        in_valid/in_ready + in_op/in_rs/in_rt/in_rd/in_imm/in_target/in_last
//        instruction stream; wr_en/wr_ready/wr_addr/wr_data imem write port;
//        busy, done, count, err_illegal, err_overflow status.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              err_overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [CNT_W-1:0]  count_q;
  logic              err_ill_q;
  logic              err_ovf_q;

  logic [31:0] pack_word;
  logic        pack_illegal;
  logic        wr_fire;
  logic        last_slot;
  logic        accept;

  instr_pack u_pack (
    .op_i      (in_op),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .imm_i     (in_imm),
    .target_i  (in_target),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

  assign wr_fire = wr_en_q & wr_ready;
  // A word pending at the top address ends the load, so nothing new may
  // enter the output register behind it and wrap into address 0.
  assign last_slot = wr_en_q & (addr_q == ADDR_MAX);
  assign in_ready  = (state_q == ST_LOAD) & (!wr_en_q | wr_ready) & !last_slot;
  assign accept    = in_valid & in_ready;

  // FSM, output register, address/count and sticky errors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= 32'd0;
      count_q   <= '0;
      err_ill_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_en_q <= 1'b0;
        addr_q  <= addr_q + ADDR_W'(1);
        count_q <= count_q + CNT_W'(1);
        if (addr_q == ADDR_MAX) err_ovf_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_LOAD;
            addr_q    <= base_addr;
            count_q   <= '0;
            err_ill_q <= 1'b0;
            err_ovf_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (wr_fire && addr_q == ADDR_MAX) state_q <= ST_DRAIN;
          if (accept) begin
            // Same-edge reload overrides the clear from the completing write
            if (pack_illegal) begin
              err_ill_q <= 1'b1;
            end else begin
              wr_en_q <= 1'b1;
              data_q  <= pack_word;
            end
            if (in_last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!wr_en_q || wr_ready) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = addr_q;
  assign wr_data      = data_q;
  assign count        = count_q;
  assign err_illegal  = err_ill_q;
  assign err_overflow = err_ovf_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule
